// File: rtl/count_seq_checker_if.sv
// rtl/count_seq_checker_if.sv - observed count bus, clear and checker status/statistics bundle.
interface count_seq_checker_if #(
  parameter int WIDTH     = 5,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     count_in;
  logic                 clr;
  logic                 locked;
  logic                 stall;
  logic                 step_pulse;
  logic                 wrap_pulse;
  logic                 err_pulse;
  logic [15:0]          wrap_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0]     last_count;

  modport master (
    output count_in, clr,
    input  locked, stall, step_pulse, wrap_pulse, err_pulse, wrap_cnt, err_cnt, last_count
  );

  modport slave (
    input  count_in, clr,
    output locked, stall, step_pulse, wrap_pulse, err_pulse, wrap_cnt, err_cnt, last_count
  );
endinterface

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - checks a sampled count bus for +1 steps (mod 2^WIDTH),
// tracking lock/stall state, wraps and sequence errors.
module count_seq_checker #(
  parameter int WIDTH     = 5,
  parameter int LOCK_CNT  = 4,
  parameter int HOLD_MAX  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  count_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {ST_ACQ, ST_LOCKED, ST_STALLED} state_e;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic [3:0]           good_run_q, good_run_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic                 step_q, step_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic [15:0]          wrap_cnt_q, wrap_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     prev_inc;
  logic                 change;
  logic                 legal;
  logic                 is_wrap;

  // Nothing is a step until a reference value has been captured after reset.
  assign prev_inc = prev_q + 1'b1;
  assign change   = have_prev_q && (bus.count_in != prev_q);
  assign legal    = change && (bus.count_in == prev_inc);
  assign is_wrap  = (bus.count_in == '0);

  always_comb begin
    state_d     = state_q;
    prev_d      = bus.count_in;
    have_prev_d = 1'b1;
    good_run_d  = good_run_q;
    hold_cnt_d  = hold_cnt_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (bus.clr) begin
      state_d    = ST_ACQ;
      good_run_d = '0;
      hold_cnt_d = '0;
      wrap_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      step_d = legal;
      case (state_q)
        ST_ACQ: begin
          if (legal) begin
            if (good_run_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_run_q + 4'd1;
            end
          end else if (change) begin
            good_run_d = '0;
          end
        end
        ST_LOCKED, ST_STALLED: begin
          if (legal) begin
            state_d    = ST_LOCKED;
            hold_cnt_d = '0;
            if (is_wrap) begin
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + 16'd1;
            end
          end else if (change) begin
            err_d      = 1'b1;
            state_d    = ST_ACQ;
            good_run_d = '0;
            hold_cnt_d = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end else if (have_prev_q && state_q == ST_LOCKED) begin
            // Stall is declared on the HOLD_MAX-th consecutive unchanged cycle.
            if (hold_cnt_q == HOLD_LAST) begin
              state_d    = ST_STALLED;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQ;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      good_run_q  <= '0;
      hold_cnt_q  <= '0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      wrap_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      good_run_q  <= good_run_d;
      hold_cnt_q  <= hold_cnt_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.stall      = (state_q == ST_STALLED);
  assign bus.step_pulse = step_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.err_pulse  = err_q;
  assign bus.wrap_cnt   = wrap_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.last_count = prev_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed count sequences with a per-cycle expectation scoreboard,
// run against an 8-bit and a 2-bit error-counter instance in parallel.
module tb_count_seq_checker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(5), .ERR_CNT_W(8)) if8 ();
  count_seq_checker_if #(.WIDTH(5), .ERR_CNT_W(2)) if2 ();

  count_seq_checker #(.WIDTH(5), .LOCK_CNT(4), .HOLD_MAX(16), .ERR_CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  count_seq_checker #(.WIDTH(5), .LOCK_CNT(4), .HOLD_MAX(16), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  typedef struct {
    int due;
    int lk, st, sp, wp, ep;
    int wc, ec, last;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endfunction

  function automatic void check_all(exp_t e);
    int ec2;
    ec2 = (e.ec > 3) ? 3 : e.ec;
    chk("d8.locked",     int'(if8.locked),     e.lk);
    chk("d8.stall",      int'(if8.stall),      e.st);
    chk("d8.step_pulse", int'(if8.step_pulse), e.sp);
    chk("d8.wrap_pulse", int'(if8.wrap_pulse), e.wp);
    chk("d8.err_pulse",  int'(if8.err_pulse),  e.ep);
    chk("d8.wrap_cnt",   int'(if8.wrap_cnt),   e.wc);
    chk("d8.err_cnt",    int'(if8.err_cnt),    e.ec);
    chk("d8.last_count", int'(if8.last_count), e.last);
    chk("d2.locked",     int'(if2.locked),     e.lk);
    chk("d2.err_pulse",  int'(if2.err_pulse),  e.ep);
    chk("d2.err_cnt",    int'(if2.err_cnt),    ec2);
  endfunction

  function automatic void rst_chk(string tag);
    chk({tag, ".locked"},     int'(if8.locked),     0);
    chk({tag, ".stall"},      int'(if8.stall),      0);
    chk({tag, ".step_pulse"}, int'(if8.step_pulse), 0);
    chk({tag, ".wrap_pulse"}, int'(if8.wrap_pulse), 0);
    chk({tag, ".err_pulse"},  int'(if8.err_pulse),  0);
    chk({tag, ".wrap_cnt"},   int'(if8.wrap_cnt),   0);
    chk({tag, ".err_cnt"},    int'(if8.err_cnt),    0);
    chk({tag, ".last_count"}, int'(if8.last_count), 0);
    chk({tag, ".d2_err_cnt"}, int'(if2.err_cnt),    0);
  endfunction

  // Monitor: each record is due on the cycle whose edge sampled its stimulus.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due != cyc) chk("record_late", cyc, e.due);
      else check_all(e);
    end
  end

  task automatic put(input int val, input int c, input int lk, input int st, input int sp,
                     input int wp, input int ep, input int wc, input int ec);
    exp_t e;
    if8.count_in = 5'(val);
    if2.count_in = 5'(val);
    if8.clr      = (c != 0);
    if2.clr      = (c != 0);
    e.due = cyc + 1;
    e.lk = lk; e.st = st; e.sp = sp; e.wp = wp; e.ep = ep;
    e.wc = wc; e.ec = ec; e.last = val;
    q.push_back(e);
  endtask

  // First cycle carries the given clr/pulses; the remaining n-1 cycles hold the value quietly.
  task automatic seg(input int val, input int n, input int c, input int lk, input int st,
                     input int sp, input int wp, input int ep, input int wc, input int ec);
    @(posedge clk); #1;
    put(val, c, lk, st, sp, wp, ep, wc, ec);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      put(val, 0, lk, st, 0, 0, 0, wc, ec);
    end
  endtask

  task automatic relock(input int start, input int wc, input int ec);
    for (int i = 0; i < 4; i++)
      seg((start + i) % 32, 1, 0, (i == 3) ? 1 : 0, 0, 1, 0, 0, wc, ec);
  endtask

  task automatic errv(input int val, input int wc, input int ec);
    seg(val, 1, 0, 0, 0, 0, 0, 1, wc, ec);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.count_in = '0; if2.count_in = '0;
    if8.clr = 1'b0;    if2.clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_chk("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Acquire on 0..4, then count up to the wrap.
    seg(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 3; v++) seg(v, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    seg(4, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int v = 5; v <= 31; v++) seg(v, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    seg(0, 3, 0, 1, 0, 1, 1, 0, 1, 0);

    // Jump 10->13 while locked, then relock on 14..17.
    for (int v = 1; v <= 10; v++) seg(v, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    errv(13, 1, 1);
    for (int v = 14; v <= 16; v++) seg(v, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    seg(17, 1, 0, 1, 0, 1, 0, 0, 1, 1);

    // Stall on a 20-cycle hold, recover with 21, stall again, then break with 25.
    seg(18, 1, 0, 1, 0, 1, 0, 0, 1, 1);
    seg(19, 1, 0, 1, 0, 1, 0, 0, 1, 1);
    seg(20, 16, 0, 1, 0, 1, 0, 0, 1, 1);
    seg(20, 5, 0, 0, 1, 0, 0, 0, 1, 1);
    seg(21, 16, 0, 1, 0, 1, 0, 0, 1, 1);
    seg(21, 3, 0, 0, 1, 0, 0, 0, 1, 1);
    seg(25, 2, 0, 0, 0, 0, 0, 1, 1, 2);

    // Five more locked errors; the 2-bit instance pins at 3.
    relock(26, 1, 2); errv(3, 1, 3);
    relock(4, 1, 3);  errv(10, 1, 4);
    relock(11, 1, 4); errv(20, 1, 5);
    relock(21, 1, 5); errv(0, 1, 6);
    relock(1, 1, 6);  errv(9, 1, 7);

    // Wrap taken straight out of STALLED.
    seg(27, 1, 0, 0, 0, 0, 0, 0, 1, 7);
    relock(28, 1, 7);
    seg(31, 15, 0, 1, 0, 0, 0, 0, 1, 7);
    seg(31, 2, 0, 0, 1, 0, 0, 0, 1, 7);
    seg(0, 1, 0, 1, 0, 1, 1, 0, 2, 7);

    // clr coinciding with an illegal 5->9 jump.
    for (int v = 1; v <= 5; v++) seg(v, 1, 0, 1, 0, 1, 0, 0, 2, 7);
    seg(9, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    seg(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    relock(10, 0, 0);
    seg(13, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    errv(20, 0, 1);
    relock(21, 0, 1);
    seg(24, 4, 0, 1, 0, 0, 0, 0, 0, 1);
    drain();

    // Asynchronous reset mid-hold, away from any clock edge.
    @(negedge clk);
    chk("pre_reset.locked",     int'(if8.locked),     1);
    chk("pre_reset.err_cnt",    int'(if8.err_cnt),    1);
    chk("pre_reset.last_count", int'(if8.last_count), 24);
    #2 rst_n = 1'b0;
    #1 rst_chk("async_reset");
    @(posedge clk); #1;
    rst_chk("held_reset");

    // Value present at release is only a reference: 1 must not count as 0->1.
    @(posedge clk); #1;
    rst_n = 1'b1;
    put(1, 0, 0, 0, 0, 0, 0, 0, 0);
    relock(2, 0, 0);
    seg(5, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receiving end of the free-running up-counter stream. Samples a WIDTH-bit count bus every clock and checks that each value change is a legal +1 step, modulo 2^WIDTH.
- Reports lock status, wrap events, sequence errors and stalls.
- Sits beside any counter source in a bench or system as a self-checking consumer, with statistics counters readable by a host.

Parameters:
- WIDTH, 5: width of the observed count bus.
- LOCK_CNT, 4: consecutive legal steps needed to declare lock (range 1..15).
- HOLD_MAX, 16: unchanged cycles in LOCKED before a stall is flagged (range 2..255).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- count_in, input, WIDTH: observed count value, synchronous to clk.
- clr, input, 1: synchronous statistics/state clear.
- locked, output, 1: high while in LOCKED.
- stall, output, 1: high while in STALLED.
- step_pulse, output, 1: one-cycle pulse per legal step.
- wrap_pulse, output, 1: one-cycle pulse per legal max->0 step while LOCKED.
- err_pulse, output, 1: one-cycle pulse per illegal step while LOCKED or STALLED.
- wrap_cnt, output, 16: wraps seen while LOCKED; rolls over at 2^16.
- err_cnt, output, ERR_CNT_W: errors seen; saturates at all-ones.
- last_count, output, WIDTH: most recent sampled count_in.

Behaviour:
- Reset (rst_n low, async): state=ACQ, prev_q=0, good_run=0, hold_cnt=0. All outputs 0.
- prev_q/last_count: register count_in every cycle, including during clr.
- Change detection: change = (count_in != prev_q). Legal step = change and count_in == prev_q+1 mod 2^WIDTH; this includes max->0. Any other change is illegal. No change is not a step.
- Latency: evaluation uses cycle-t values. Pulses and counter updates are visible at t+1. Every pulse lasts exactly one cycle.
- step_pulse fires on every legal step, in any state.
- ACQ:
  - Legal step: good_run++. If good_run reaches LOCK_CNT, go to LOCKED and clear good_run.
  - Illegal step: good_run=0. No err_pulse, no err_cnt change.
  - wrap_pulse is not asserted in ACQ.
- LOCKED:
  - Legal step: hold_cnt=0. If the step is max->0, pulse wrap_pulse and increment wrap_cnt.
  - Illegal step: err_pulse, err_cnt+1 (saturating), go to ACQ with good_run=0.
  - No change: hold_cnt++. When hold_cnt reaches HOLD_MAX, go to STALLED; stall=1 on the following cycle.
- STALLED:
  - Legal step: go to LOCKED, hold_cnt=0, stall=0. A max->0 step also counts as a wrap.
  - Illegal step: err_pulse, err_cnt+1, go to ACQ.
  - No change: remain in STALLED.
- locked is high in LOCKED only; it drops the cycle after a stall or error transition. stall is high in STALLED only.
- clr (synchronous, highest priority over step evaluation):
  - Clears wrap_cnt, err_cnt, good_run and hold_cnt; state=ACQ.
  - No pulses in the clr cycle's result, even if a change occurs.
  - prev_q still updates.
- Async reset mid-operation: all outputs 0 immediately, independent of clk. Reacquire from scratch after release.
- The first observed value after reset or clr is a reference only. A legal step requires a prior value in prev_q.

Test Plan:
- Reset; drive 0,1,2,... each held 3 cycles (LOCK_CNT=4) -> step_pulse per change; locked=1 one cycle after the 0->4... change sequence completes the 4th legal step (value 4); wrap_cnt=0, err_cnt=0.
- Continue to 31 then 0 -> wrap_pulse single cycle, one cycle after 0 appears; wrap_cnt=1; locked stays 1.
- While locked, jump 10->13 -> err_pulse one cycle, err_cnt=1, locked=0 the next cycle. Then 14,15,16,17 -> locked=1 after 17; err_cnt stays 1.
- While locked, hold 20 for 20 cycles (HOLD_MAX=16) -> stall=1 and locked=0 after the 16th unchanged cycle. Drive 21 -> stall=0, locked=1, step_pulse. Repeat the hold, then drive 25 -> err_pulse, state ACQ.
- ERR_CNT_W=2: produce 5 locked errors, relocking between each -> err_cnt=3 after the 3rd error and stays 3.
- Assert clr in the same cycle as an illegal 5->9 change while locked -> no err_pulse, err_cnt=0, wrap_cnt=0, locked=0. Pulse rst_n low mid-hold -> all outputs 0 asynchronously.
